// File: rtl/change_dispenser.sv
// Change dispenser: breaks a refund into 10/5/1 coins greedily, hands them to the
// coin hopper one at a time, and tracks per-denomination inventory.
module change_dispenser #(
    parameter int INV_W   = 8,
    parameter int INIT_10 = 8,
    parameter int INIT_5  = 8,
    parameter int INIT_1  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             refund_valid,
    input  logic [5:0]       refund,
    output logic             refund_ready,
    output logic             coin_valid,
    output logic [5:0]       coin_value,
    input  logic             coin_ready,
    input  logic             restock,
    input  logic [INV_W-1:0] restock_10,
    input  logic [INV_W-1:0] restock_5,
    input  logic [INV_W-1:0] restock_1,
    output logic [INV_W-1:0] inv_10,
    output logic [INV_W-1:0] inv_5,
    output logic [INV_W-1:0] inv_1,
    output logic             done,
    output logic [5:0]       short_amount,
    output logic             short_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_DISPENSE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       remaining_q, remaining_d;
    logic [5:0]       coin_q, coin_d;
    logic [5:0]       short_q, short_d;
    logic             short_err_q, short_err_d;
    logic [INV_W-1:0] inv_10_q, inv_10_d;
    logic [INV_W-1:0] inv_5_q, inv_5_d;
    logic [INV_W-1:0] inv_1_q, inv_1_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            coin_q      <= '0;
            short_q     <= '0;
            short_err_q <= 1'b0;
            inv_10_q    <= INV_W'(INIT_10);
            inv_5_q     <= INV_W'(INIT_5);
            inv_1_q     <= INV_W'(INIT_1);
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            coin_q      <= coin_d;
            short_q     <= short_d;
            short_err_q <= short_err_d;
            inv_10_q    <= inv_10_d;
            inv_5_q     <= inv_5_d;
            inv_1_q     <= inv_1_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        coin_d      = coin_q;
        short_d     = short_q;
        short_err_d = short_err_q;
        inv_10_d    = inv_10_q;
        inv_5_d     = inv_5_q;
        inv_1_d     = inv_1_q;

        case (state_q)
            S_IDLE: begin
                // An accept takes priority over a simultaneous restock.
                if (refund_valid) begin
                    remaining_d = refund;
                    short_d     = '0;
                    short_err_d = 1'b0;
                    state_d     = S_SELECT;
                end else if (restock) begin
                    inv_10_d = restock_10;
                    inv_5_d  = restock_5;
                    inv_1_d  = restock_1;
                end
            end
            S_SELECT: begin
                if (remaining_q >= 6'd10 && inv_10_q != '0) begin
                    coin_d  = 6'd10;
                    state_d = S_DISPENSE;
                end else if (remaining_q >= 6'd5 && inv_5_q != '0) begin
                    coin_d  = 6'd5;
                    state_d = S_DISPENSE;
                end else if (remaining_q >= 6'd1 && inv_1_q != '0) begin
                    coin_d  = 6'd1;
                    state_d = S_DISPENSE;
                end else begin
                    // Registered here so the result is visible during the DONE cycle.
                    short_d     = remaining_q;
                    short_err_d = (remaining_q != '0);
                    state_d     = S_DONE;
                end
            end
            S_DISPENSE: begin
                if (coin_ready) begin
                    remaining_d = remaining_q - coin_q;
                    case (coin_q)
                        6'd10:   inv_10_d = inv_10_q - 1'b1;
                        6'd5:    inv_5_d  = inv_5_q - 1'b1;
                        default: inv_1_d  = inv_1_q - 1'b1;
                    endcase
                    state_d = S_SELECT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign refund_ready = (state_q == S_IDLE);
    assign coin_valid   = (state_q == S_DISPENSE);
    assign coin_value   = (state_q == S_DISPENSE) ? coin_q : '0;
    assign done         = (state_q == S_DONE);
    assign short_amount = short_q;
    assign short_err    = short_err_q;
    assign inv_10       = inv_10_q;
    assign inv_5        = inv_5_q;
    assign inv_1        = inv_1_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed refunds checked against a per-cycle
// greedy-payout model plus hand-computed literal expectations.
module tb_change_dispenser;

    localparam int INV_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             refund_valid;
    logic [5:0]       refund;
    logic             refund_ready;
    logic             coin_valid;
    logic [5:0]       coin_value;
    logic             coin_ready;
    logic             restock;
    logic [INV_W-1:0] restock_10, restock_5, restock_1;
    logic [INV_W-1:0] inv_10, inv_5, inv_1;
    logic             done;
    logic [5:0]       short_amount;
    logic             short_err;

    change_dispenser #(
        .INV_W  (8),
        .INIT_10(8),
        .INIT_5 (8),
        .INIT_1 (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .refund_valid(refund_valid),
        .refund      (refund),
        .refund_ready(refund_ready),
        .coin_valid  (coin_valid),
        .coin_value  (coin_value),
        .coin_ready  (coin_ready),
        .restock     (restock),
        .restock_10  (restock_10),
        .restock_5   (restock_5),
        .restock_1   (restock_1),
        .inv_10      (inv_10),
        .inv_5       (inv_5),
        .inv_1       (inv_1),
        .done        (done),
        .short_amount(short_amount),
        .short_err   (short_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Model state: inventory, coins still owed for the current refund, shortfall.
    int denom[3] = '{10, 5, 1};
    int m_inv[3];
    int exp_coins[$];
    int exp_short;
    int m_short_shown;
    int coin_log[$];

    function automatic void model_reset();
        m_inv[0] = 8;
        m_inv[1] = 8;
        m_inv[2] = 16;
        exp_coins.delete();
        exp_short     = 0;
        m_short_shown = 0;
    endfunction

    function automatic void plan(input int amt);
        int rem;
        int n;
        rem = amt;
        for (int i = 0; i < 3; i++) begin
            n = rem / denom[i];
            if (n > m_inv[i]) n = m_inv[i];
            repeat (n) exp_coins.push_back(denom[i]);
            rem -= n * denom[i];
        end
        exp_short = rem;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            check("inv_10", inv_10, m_inv[0]);
            check("inv_5", inv_5, m_inv[1]);
            check("inv_1", inv_1, m_inv[2]);
            if (done) begin
                m_short_shown = exp_short;
                check("coins_left_at_done", exp_coins.size(), 0);
            end
            check("short_amount", short_amount, m_short_shown);
            check("short_err", short_err, int'(m_short_shown != 0));
            if (coin_valid) begin
                if (exp_coins.size() == 0) begin
                    check("coin_expected", int'(exp_coins.size() != 0), 1);
                end else begin
                    check("coin_value", coin_value, exp_coins[0]);
                    if (coin_ready) begin
                        case (exp_coins[0])
                            10:      m_inv[0]--;
                            5:       m_inv[1]--;
                            default: m_inv[2]--;
                        endcase
                        coin_log.push_back(int'(coin_value));
                        void'(exp_coins.pop_front());
                    end
                end
            end else begin
                check("coin_value_idle", coin_value, 0);
            end
            if (refund_ready && refund_valid) begin
                plan(int'(refund));
                m_short_shown = 0;
            end else if (refund_ready && restock) begin
                m_inv[0] = int'(restock_10);
                m_inv[1] = int'(restock_5);
                m_inv[2] = int'(restock_1);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic accept(input int amt);
        @(posedge clk); #1;
        check("accept_ready", refund_ready, 1);
        refund       = 6'(amt);
        refund_valid = 1'b1;
        @(posedge clk); #1;
        refund_valid = 1'b0;
    endtask

    task automatic do_restock(input int a, input int b, input int c);
        @(posedge clk); #1;
        restock    = 1'b1;
        restock_10 = INV_W'(a);
        restock_5  = INV_W'(b);
        restock_1  = INV_W'(c);
        @(posedge clk); #1;
        restock = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        check("done_seen", int'(seen), 1);
    endtask

    task automatic check_log(input string name, input int exp_q[$]);
        check({name, "_count"}, coin_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < coin_log.size(); i++)
            check(name, coin_log[i], exp_q[i]);
    endtask

    initial begin
        reset        = 1'b1;
        refund_valid = 1'b0;
        refund       = '0;
        coin_ready   = 1'b1;
        restock      = 1'b0;
        restock_10   = '0;
        restock_5    = '0;
        restock_1    = '0;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset state
        check("rst_refund_ready", refund_ready, 1);
        check("rst_coin_valid", coin_valid, 0);
        check("rst_coin_value", coin_value, 0);
        check("rst_done", done, 0);
        check("rst_short", short_amount, 0);
        check("rst_short_err", short_err, 0);
        check("rst_inv_10", inv_10, 8);
        check("rst_inv_5", inv_5, 8);
        check("rst_inv_1", inv_1, 16);

        // 1: refund 27 from full inventory, with first-coin latency
        coin_log.delete();
        accept(27);
        check("t1_select_no_coin", coin_valid, 0);
        @(posedge clk); #1;
        check("t1_first_coin_valid", coin_valid, 1);
        wait_done(40);
        check_log("t1_coin", '{10, 10, 5, 1, 1});
        check("t1_short", short_amount, 0);
        check("t1_inv_10", inv_10, 6);
        check("t1_inv_5", inv_5, 7);
        check("t1_inv_1", inv_1, 14);

        // 2: refund 0 finishes two edges after the accept with no coins
        coin_log.delete();
        accept(0);
        check("t2_done_early", done, 0);
        check("t2_coin_valid0", coin_valid, 0);
        @(posedge clk); #1;
        check("t2_done", done, 1);
        check("t2_coin_valid1", coin_valid, 0);
        check("t2_short_err", short_err, 0);
        check("t2_coin_count", coin_log.size(), 0);

        // 3: no tens, fall back to fives
        do_restock(0, 4, 16);
        check("t3_restock_inv_5", inv_5, 4);
        coin_log.delete();
        accept(20);
        wait_done(40);
        check_log("t3_coin", '{5, 5, 5, 5});
        check("t3_inv_5", inv_5, 0);
        check("t3_inv_1", inv_1, 16);

        // 4: not enough coins, shortfall reported and held
        do_restock(0, 0, 2);
        coin_log.delete();
        accept(3);
        wait_done(40);
        check_log("t4_coin", '{1, 1});
        check("t4_short", short_amount, 1);
        check("t4_short_err", short_err, 1);
        repeat (3) @(posedge clk);
        #1;
        check("t4_short_held", short_amount, 1);
        check("t4_inv_1", inv_1, 0);

        // 5: hopper stalls on the first coin; restock mid-payout is ignored
        do_restock(3, 3, 3);
        coin_log.delete();
        coin_ready = 1'b0;
        accept(10);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t5_hold_valid", coin_valid, 1);
            check("t5_hold_value", coin_value, 10);
            check("t5_hold_inv_10", inv_10, 3);
            restock = (i == 2);
        end
        restock    = 1'b0;
        coin_ready = 1'b1;
        wait_done(40);
        check_log("t5_coin", '{10});
        check("t5_inv_10", inv_10, 2);
        check("t5_inv_5", inv_5, 3);

        // 6: reset mid-dispense, then restock collides with an accept
        coin_ready = 1'b0;
        accept(27);
        @(posedge clk); #1;
        check("t6_dispensing", coin_valid, 1);
        reset = 1'b1;
        model_reset();
        #1;
        check("t6_rst_coin_valid", coin_valid, 0);
        check("t6_rst_ready", refund_ready, 1);
        check("t6_rst_inv_10", inv_10, 8);
        check("t6_rst_inv_5", inv_5, 8);
        check("t6_rst_inv_1", inv_1, 16);
        @(posedge clk); #1;
        reset      = 1'b0;
        coin_ready = 1'b1;
        coin_log.delete();
        @(posedge clk); #1;
        restock      = 1'b1;
        restock_10   = 8'd1;
        restock_5    = 8'd1;
        restock_1    = 8'd1;
        refund       = 6'd5;
        refund_valid = 1'b1;
        @(posedge clk); #1;
        restock      = 1'b0;
        refund_valid = 1'b0;
        wait_done(40);
        check_log("t6_coin", '{5});
        check("t6_inv_10", inv_10, 8);
        check("t6_inv_5", inv_5, 7);
        check("t6_inv_1", inv_1, 16);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
